// File: rtl/store_buffer_pkg.sv
// Shared dmem size codes, port enable levels and the store alignment rule used by
// the store buffer, dmem and the control unit.
package store_buffer_pkg;
    localparam logic [1:0] CS_W          = 2'b01;
    localparam logic [1:0] CS_H          = 2'b10;
    localparam logic [1:0] CS_B          = 2'b11;
    localparam logic       ENABLED       = 1'b1;
    localparam logic       WRITE_ENABLED = 1'b1;

    // Alignment is judged on the offset from the data segment base.
    function automatic logic misaligned(input logic [1:0] cs, input logic [31:0] addr,
                                        input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return ((cs == CS_W) && (off[1:0] != 2'b00)) || ((cs == CS_H) && off[0]);
    endfunction
endpackage

// File: rtl/store_buffer_sb_fifo.sv
// Store entry storage: program-order FIFO with per-entry word-address match vector
// so the top can detect load-after-store hazards against every queued store.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [1:0]        i_cs,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_data,
    input  logic              i_pop,
    input  logic [29:0]       i_cmp_waddr,
    output logic [1:0]        o_head_cs,
    output logic [31:0]       o_head_addr,
    output logic [31:0]       o_head_data,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic [DEPTH-1:0]  o_match
);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [1:0]       r_cs   [DEPTH];
    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            // Pop clears before push sets so a push into the slot just freed wins.
            if (i_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + P_ONE;
            end
            if (i_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + P_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_cs[r_tail]   <= i_cs;
            r_addr[r_tail] <= i_addr;
            r_data[r_tail] <= i_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign o_match[i] = r_vld[i] && (r_addr[i][31:2] == i_cmp_waddr);
    end

    assign o_head_cs   = r_cs[r_head];
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of single-port dmem: loads own the port, queued stores
// drain in idle cycles, and a full buffer forces a drain so loads cannot starve it.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] DMEM_BASE = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [1:0]  st_cs,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_misalign,
    input  logic        ld_valid,
    input  logic [1:0]  ld_cs,
    input  logic        ld_signed,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic [31:0] ld_data,
    output logic        dm_ena,
    output logic        dm_wena,
    output logic [1:0]  dm_w_cs,
    output logic [1:0]  dm_r_cs,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        empty
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]       w_head_cs;
    logic [31:0]      w_head_addr, w_head_data;
    logic [CW-1:0]    w_count;
    logic             w_full, w_empty, w_push, w_ld_go, w_drain;
    logic [DEPTH-1:0] w_match;

    assign st_misalign = st_valid && misaligned(st_cs, st_addr, DMEM_BASE);
    assign st_ready    = !w_full;
    assign w_push      = st_valid && st_ready && !st_misalign;

    // Hazard sees only entries already queued; a same-cycle store is younger.
    assign ld_stall = ld_valid && ((|w_match) || w_full);
    assign w_ld_go  = ld_valid && !ld_stall && !rst;
    assign w_drain  = !w_ld_go && !w_empty && !rst;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_cs       (st_cs),
        .i_addr     (st_addr),
        .i_data     (st_data),
        .i_pop      (w_drain),
        .i_cmp_waddr(ld_addr[31:2]),
        .o_head_cs  (w_head_cs),
        .o_head_addr(w_head_addr),
        .o_head_data(w_head_data),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_match    (w_match)
    );

    assign dm_ena   = (w_ld_go || w_drain) ? ENABLED : ~ENABLED;
    assign dm_wena  = w_drain ? WRITE_ENABLED : ~WRITE_ENABLED;
    assign dm_r_cs  = w_ld_go ? ld_cs : 2'b00;
    assign dm_w_cs  = w_head_cs;
    assign dm_addr  = w_ld_go ? ld_addr : w_head_addr;
    assign dm_wdata = w_head_data;
    assign empty    = w_empty;

    always_comb begin
        ld_data = dm_rdata;
        case (ld_cs)
            CS_H:    ld_data = {{16{ld_signed & dm_rdata[15]}}, dm_rdata[15:0]};
            CS_B:    ld_data = {{24{ld_signed & dm_rdata[7]}}, dm_rdata[7:0]};
            default: ld_data = dm_rdata;
        endcase
    end

    logic w_unused;
    assign w_unused = ^w_count;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain timing, full/hazard stalls, load extension,
// misaligned drop and reset mid-drain, all against hand-computed values.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready, st_misalign;
    logic [1:0]  st_cs;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_signed, ld_stall;
    logic [1:0]  ld_cs;
    logic [31:0] ld_addr, ld_data;
    logic        dm_ena, dm_wena;
    logic [1:0]  dm_w_cs, dm_r_cs;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        empty;

    int n_cmp = 0;
    int n_err = 0;

    store_buffer dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_cs(st_cs), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .st_misalign(st_misalign),
        .ld_valid(ld_valid), .ld_cs(ld_cs), .ld_signed(ld_signed), .ld_addr(ld_addr),
        .ld_stall(ld_stall), .ld_data(ld_data),
        .dm_ena(dm_ena), .dm_wena(dm_wena), .dm_w_cs(dm_w_cs), .dm_r_cs(dm_r_cs),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and checks happen 1-2 time units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_st(input logic [1:0] cs, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_cs = cs; st_addr = a; st_data = d;
    endtask

    initial begin
        rst = 1'b1; st_valid = 0; st_cs = 0; st_addr = 0; st_data = 0;
        ld_valid = 0; ld_cs = 0; ld_signed = 0; ld_addr = 0; dm_rdata = 0;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_ena", 32'(dm_ena), 32'd0);
        chk("rst_wena", 32'(dm_wena), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // 1: single SW drains the cycle after acceptance
        put_st(2'b01, 32'h1001_0000, 32'hDEAD_BEEF);
        #1 chk("t1_idle_ena", 32'(dm_ena), 32'd0);
        tick(); st_valid = 0; #1;
        chk("t1_wena", 32'(dm_wena), 32'd1);
        chk("t1_addr", dm_addr, 32'h1001_0000);
        chk("t1_wdata", dm_wdata, 32'hDEAD_BEEF);
        chk("t1_wcs", 32'(dm_w_cs), 32'd1);
        chk("t1_notempty", 32'(empty), 32'd0);
        tick(); #1;
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_ena_off", 32'(dm_ena), 32'd0);

        // 2: four SBs while an unrelated load owns the port
        ld_valid = 1; ld_cs = 2'b01; ld_addr = 32'h1001_0100;
        for (int i = 0; i < 4; i++) begin
            put_st(2'b11, 32'h1001_0010 + 32'(i), 32'(8'hA0 + i));
            #1 chk("t2_ld_owns", 32'({dm_ena, dm_wena}), 32'b10);
            tick();
        end
        st_valid = 0; #1;
        chk("t2_ready0", 32'(st_ready), 32'd0);
        chk("t2_stall_full", 32'(ld_stall), 32'd1);
        chk("t2_forced_drain", 32'(dm_wena), 32'd1);
        chk("t2_drain_addr", dm_addr, 32'h1001_0010);
        chk("t2_drain_data", dm_wdata, 32'h0000_00A0);
        tick(); #1;
        chk("t2_stall_clr", 32'(ld_stall), 32'd0);
        chk("t2_ld_issue", 32'({dm_ena, dm_wena}), 32'b10);
        chk("t2_ld_addr", dm_addr, 32'h1001_0100);
        chk("t2_ready1", 32'(st_ready), 32'd1);
        ld_valid = 0;
        tick(); tick(); tick(); #1;
        chk("t2_drained", 32'(empty), 32'd1);

        // 2b: same-cycle store to the load's word is younger, no stall until queued
        put_st(2'b01, 32'h1001_0020, 32'h1234_5678);
        ld_valid = 1; ld_cs = 2'b01; ld_addr = 32'h1001_0020;
        #1 chk("t2b_no_stall", 32'(ld_stall), 32'd0);
        tick(); st_valid = 0; #1;
        chk("t2b_stall", 32'(ld_stall), 32'd1);
        chk("t2b_drain", 32'(dm_wena), 32'd1);
        tick(); #1;
        chk("t2b_unstall", 32'(ld_stall), 32'd0);
        ld_valid = 0;

        // 3: SH hazard on the same word, then signed LH extension
        put_st(2'b10, 32'h1001_0006, 32'h0000_8001);
        tick(); st_valid = 0;
        ld_valid = 1; ld_cs = 2'b10; ld_signed = 1; ld_addr = 32'h1001_0004;
        #1;
        chk("t3_stall", 32'(ld_stall), 32'd1);
        chk("t3_drain_addr", dm_addr, 32'h1001_0006);
        chk("t3_drain_cs", 32'(dm_w_cs), 32'd2);
        tick(); dm_rdata = 32'h0000_FFFF; #1;
        chk("t3_unstall", 32'(ld_stall), 32'd0);
        chk("t3_rd", 32'({dm_ena, dm_wena, dm_r_cs}), 32'b1010);
        chk("t3_lh_s", ld_data, 32'hFFFF_FFFF);
        ld_signed = 0; #1 chk("t3_lh_u", ld_data, 32'h0000_FFFF);

        // 4: byte and word extension
        ld_cs = 2'b11; dm_rdata = 32'h0000_0080; #1;
        chk("t4_lb_u", ld_data, 32'h0000_0080);
        ld_signed = 1; #1 chk("t4_lb_s", ld_data, 32'hFFFF_FF80);
        ld_cs = 2'b01; dm_rdata = 32'h8765_43F0; #1;
        chk("t4_lw", ld_data, 32'h8765_43F0);
        ld_valid = 0; ld_signed = 0;

        // 5: misaligned stores are dropped
        put_st(2'b01, 32'h1001_0002, 32'h5555_5555);
        #1 chk("t5_sw_mis", 32'(st_misalign), 32'd1);
        tick(); st_valid = 0; #1;
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_no_write", 32'(dm_ena), 32'd0);
        put_st(2'b10, 32'h1001_0003, 32'h0);
        #1 chk("t5_sh_mis", 32'(st_misalign), 32'd1);
        put_st(2'b11, 32'h1001_0003, 32'h0);
        #1 chk("t5_sb_ok", 32'(st_misalign), 32'd0);
        st_valid = 0;

        // 6: reset while two stores are pending
        ld_valid = 1; ld_cs = 2'b01; ld_addr = 32'h1001_0200;
        put_st(2'b01, 32'h1001_0040, 32'h1111_1111); tick();
        put_st(2'b01, 32'h1001_0044, 32'h2222_2222); tick();
        st_valid = 0; ld_valid = 0; #1;
        chk("t6_draining", 32'(dm_wena), 32'd1);
        rst = 1'b1; #1;
        chk("t6_ena_off", 32'(dm_ena), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_write", 32'(dm_ena), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
